// File: rtl/immediate_encoder.sv
// immediate_encoder: packs opcode, register fields, funct fields and a 32-bit
// immediate into an RV32I instruction word (inverse of the immediate decoder).
// Two-stage valid/ready pipeline:
//   stage 1 - register request, classify format, range-check immediate
//   stage 2 - assemble the word (or NOP_WORD on error), hold under backpressure
// Optional build macro: ENCODER_RANGE_CHECK_EN
//   defined   : immediates outside their field range are flagged as errors
//   undefined : immediates are truncated to the field, only bad opcodes error
module immediate_encoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [6:0]       op_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      immediate_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      instruction_o,
  output logic             error_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int STAGES = 2;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } rsp_t;

  // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 occupied
  logic [STAGES:1] vld_pipe;

  req_t  in_req;
  fmt_e  in_fmt;
  logic  in_range_ok;
  logic  in_fire;

  req_t  s1_req;
  fmt_e  s1_fmt;
  logic  s1_err;
  logic  s2_adv;
  logic  s1_move;

  logic [31:0] asm_word;
  rsp_t        s2_rsp;
  logic        out_fire;

  // ------------------------------------------------------------------
  // Format classification by opcode
  // ------------------------------------------------------------------
  function automatic fmt_e classify(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return FMT_I;
      7'h23:               return FMT_S;
      7'h63:               return FMT_B;
      7'h37:               return FMT_U;
      7'h6F:               return FMT_J;
      7'h33:               return FMT_R;
      default:             return FMT_BAD;
    endcase
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  // True when every bit of the vector equals every other (a pure sign copy)
  function automatic logic all_same(input logic [20:0] v, input int n);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int b = 0; b < 21; b++) begin
      if (b < n) begin
        ones  = ones  & v[b];
        zeros = zeros & ~v[b];
      end
    end
    return ones | zeros;
  endfunction

  // Immediate must fit the field it is packed into; R ignores the immediate
  function automatic logic range_ok(input fmt_e fmt, input logic [31:0] imm);
    case (fmt)
      FMT_I, FMT_S: return all_same(imm[31:11], 21);
      FMT_B:        return !imm[0] && all_same({1'b0, imm[31:12]}, 20);
      FMT_J:        return !imm[0] && all_same({9'd0, imm[31:20]}, 12);
      FMT_U:        return imm[11:0] == 12'd0;
      default:      return 1'b1;
    endcase
  endfunction

  assign in_range_ok = range_ok(in_fmt, immediate_i);
`else
  // Without range checking the immediate is simply truncated to its field
  assign in_range_ok = 1'b1;
`endif

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  assign s2_adv   = !vld_pipe[2] || ready_i;
  assign ready_o  = !vld_pipe[1] || s2_adv;
  assign in_fire  = valid_i && ready_o;
  assign s1_move  = vld_pipe[1] && s2_adv;
  assign out_fire = vld_pipe[2] && ready_i;
  assign valid_o  = vld_pipe[2];

  assign in_req = '{op:     op_i,
                    rd:     rd_i,
                    rs1:    rs1_i,
                    rs2:    rs2_i,
                    funct3: funct3_i,
                    funct7: funct7_i,
                    imm:    immediate_i};
  assign in_fmt = classify(op_i);

  // Valid pipeline: stage 1 refills whenever it can accept, stage 2 whenever it can advance
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      if (ready_o) vld_pipe[1] <= valid_i;
      if (s2_adv)  vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Stage 1 payload: captured request plus its format and error flag
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_req <= in_req;
      s1_fmt <= in_fmt;
      s1_err <= (in_fmt == FMT_BAD) || !in_range_ok;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2 field packing
  // ------------------------------------------------------------------
  // Scatter immediate bits into the format-specific instruction fields
  always_comb begin
    asm_word = NOP_WORD;
    case (s1_fmt)
      FMT_I: asm_word = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3,
                         s1_req.rd, s1_req.op};
      FMT_S: asm_word = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1,
                         s1_req.funct3, s1_req.imm[4:0], s1_req.op};
      FMT_B: asm_word = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2,
                         s1_req.rs1, s1_req.funct3, s1_req.imm[4:1],
                         s1_req.imm[11], s1_req.op};
      FMT_U: asm_word = {s1_req.imm[31:12], s1_req.rd, s1_req.op};
      FMT_J: asm_word = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                         s1_req.imm[19:12], s1_req.rd, s1_req.op};
      FMT_R: asm_word = {s1_req.funct7, s1_req.rs2, s1_req.rs1,
                         s1_req.funct3, s1_req.rd, s1_req.op};
      default: asm_word = NOP_WORD;
    endcase
  end

  // Stage 2 register: loads only when stage 1 moves, so it holds under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_rsp <= '0;
    end else if (s1_move) begin
      s2_rsp.word <= s1_err ? NOP_WORD : asm_word;
      s2_rsp.err  <= s1_err;
    end
  end

  assign instruction_o = s2_rsp.word;
  assign error_o       = s2_rsp.err;

  // Delivered-word and error counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      count_o     <= '0;
      err_count_o <= '0;
    end else if (out_fire) begin
      count_o <= count_o + CNT_W'(1);
      if (s2_rsp.err) err_count_o <= err_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: scoreboard of expected words,
// pushed on input acceptance and popped on output transfer.
module tb_immediate_encoder;

  localparam int          CNT_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [6:0]       op_i = '0;
  logic [4:0]       rd_i = '0;
  logic [4:0]       rs1_i = '0;
  logic [4:0]       rs2_i = '0;
  logic [2:0]       funct3_i = '0;
  logic [6:0]       funct7_i = '0;
  logic [31:0]      immediate_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [31:0]      instruction_o;
  logic             error_o;
  logic [CNT_W-1:0] count_o;
  logic [CNT_W-1:0] err_count_o;

  immediate_encoder #(.CNT_W(CNT_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .immediate_i(immediate_i),
    .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o),
    .error_o(error_o), .count_o(count_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t             sb[$];
  exp_t             cur_exp;
  exp_t             got_exp;
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_err;
  logic             stall_prev = 1'b0;
  logic [31:0]      prev_word;
  logic             prev_err;
  logic             rand_rdy = 1'b0;

  // Monitor: counters, hold-under-stall, output scoreboard, input capture
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_cnt      = '0;
      m_err      = '0;
      stall_prev = 1'b0;
    end else begin
      chk("count", 32'(count_o), 32'(m_cnt));
      chk("err_count", 32'(err_count_o), 32'(m_err));
      if (stall_prev) begin
        chk("hold_word", instruction_o, prev_word);
        chk("hold_err", 32'(error_o), 32'(prev_err));
      end
      if (valid_o && ready_i) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got_exp = sb.pop_front();
          chk("word", instruction_o, got_exp.w);
          chk("err", 32'(error_o), 32'(got_exp.e));
          m_cnt = m_cnt + CNT_W'(1);
          if (got_exp.e) m_err = m_err + CNT_W'(1);
        end
      end
      stall_prev = valid_o && !ready_i;
      prev_word  = instruction_o;
      prev_err   = error_o;
      if (valid_i && ready_o) sb.push_back(cur_exp);
    end
  end

  // Reference encoding built from shifts and masks
  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] i);
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (op)
      7'h13, 7'h03, 7'h67:
        return ((i & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      7'h23:
        return (((i >> 5) & 32'h7F) << 25) | regs | ((i & 32'h1F) << 7) | 32'(op);
      7'h63:
        return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | regs |
               (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'(op);
      7'h37:
        return (i & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      7'h6F:
        return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
               (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      7'h33:
        return (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
      default: return NOP;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  // Drive one request and wait (bounded) for acceptance
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ew, input logic ee);
    int   guard;
    logic acc;
    guard       = 0;
    acc         = 1'b0;
    op_i        = op;
    rd_i        = rd;
    rs1_i       = rs1;
    rs2_i       = rs2;
    funct3_i    = f3;
    funct7_i    = f7;
    immediate_i = imm;
    cur_exp     = '{w: ew, e: ee};
    valid_i     = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_o;
      tick();
      guard++;
    end while (!acc && guard < 50);
    chk("accept", 32'(acc), 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g        = 0;
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    while (sb.size() != 0 && g < 20) begin
      tick();
      g++;
    end
    tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  logic [6:0]  ops [8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33};
  logic [15:0] save_cnt;
  logic [31:0] save_word;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_word", instruction_o, 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_cnt", 32'(count_o), 32'd0);
    chk("rst_errcnt", 32'(err_count_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);

    // addi x1,x0,5 with latency check
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    chk("lat1_valid", 32'(valid_o), 32'd0);
    tick();
    chk("lat2_valid", 32'(valid_o), 32'd1);
    chk("lat2_word", instruction_o, 32'h00500093);
    tick();
    chk("addi_cnt", 32'(count_o), 32'd1);

    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE512E23, 1'b0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8, 32'hFE000CE3, 1'b0);
    drain();

    // back-to-back jal / lui
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
    send(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123451B7, 1'b0);
    chk("burst1_valid", 32'(valid_o), 32'd1);
    chk("burst1_word", instruction_o, 32'h001000EF);
    tick();
    chk("burst2_valid", 32'(valid_o), 32'd1);
    chk("burst2_word", instruction_o, 32'h123451B7);
    drain();

    // error cases
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, NOP, 1'b1);
`ifdef ENCODER_RANGE_CHECK_EN
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3, NOP, 1'b1);
    send(7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, NOP, 1'b1);
`else
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3, 32'h00000163, 1'b0);
    send(7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001237, 1'b0);
`endif
    drain();

    // backpressure: two in flight, ready_i low for 3 cycles
    ready_i = 1'b0;
    send(7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF08113, 1'b0);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
    save_cnt  = count_o;
    save_word = instruction_o;
    chk("bp_word", save_word, 32'hFFF08113);
    repeat (3) begin
      chk("bp_ready", 32'(ready_o), 32'd0);
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_cnt", 32'(count_o), 32'(save_cnt));
      tick();
    end
    drain();

    // random burst with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] r, imm;
      op  = ops[$urandom_range(0, 7)];
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      f7  = 7'($urandom_range(0, 127));
      r   = $urandom;
      case (op)
        7'h63:   imm = {{19{r[12]}}, r[12:1], 1'b0};
        7'h37:   imm = {r[31:12], 12'd0};
        7'h6F:   imm = {{11{r[20]}}, r[20:1], 1'b0};
        default: imm = {{20{r[11]}}, r[11:0]};
      endcase
      send(op, rd, rs1, rs2, f3, f7, imm, ref_enc(op, rd, rs1, rs2, f3, f7, imm), 1'b0);
    end
    drain();

    // reset mid-stream
    send(7'h13, 5'd7, 5'd7, 5'd0, 3'd1, 7'd0, 32'd100, 32'h06439393, 1'b0);
    send(7'h13, 5'd8, 5'd8, 5'd0, 3'd1, 7'd0, 32'd1, 32'h00141413, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_cnt", 32'(count_o), 32'd0);
    chk("mrst_errcnt", 32'(err_count_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_after_valid", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
